// File: rtl/clip_sequencer.sv
// clip_sequencer: arbitrates flash_manager traffic between USB recording and clip playback.
// Holds a clip table, prefetches playback words into a small FIFO and hands one sample to
// the AC97 on each ready strobe.
module clip_sequencer #(
    parameter int unsigned ADDR_W     = 23,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned NCLIPS     = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ready,
    input  logic                       cfg_we,
    input  logic [$clog2(NCLIPS)-1:0]  cfg_sel,
    input  logic [ADDR_W-1:0]          cfg_start,
    input  logic [ADDR_W-1:0]          cfg_len,
    input  logic                       play_req,
    input  logic [$clog2(NCLIPS)-1:0]  play_sel,
    input  logic                       stop,
    input  logic                       record_en,
    input  logic [7:0]                 wr_byte,
    input  logic                       wr_valid,
    output logic [7:0]                 to_ac97_data,
    output logic                       playing,
    output logic                       underrun,
    output logic                       wr_overflow,
    output logic                       fm_writemode,
    output logic [15:0]                fm_wdata,
    output logic                       fm_dowrite,
    output logic [ADDR_W-1:0]          fm_raddr,
    output logic                       fm_doread,
    input  logic                       fm_busy,
    input  logic [15:0]                fm_frdata
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullC = CntW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StPlay,
        StDrain,
        StRecEnter,
        StRec,
        StRecExit
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] tab_start_q [NCLIPS];
    logic [ADDR_W-1:0] tab_len_q   [NCLIPS];

    logic [ADDR_W-1:0] fetch_addr_q, fetch_cnt_q, play_cnt_q, raddr_q;
    logic [ADDR_W-1:0] pend_start_q, pend_len_q;
    logic              pend_play_q;
    logic              rd_out_q, busy_q;
    logic [7:0]        fifo_mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CntW-1:0]   count_q;
    logic [7:0]        ac97_q;
    logic              underrun_q, overflow_q;
    logic [15:0]       wdata_q;

    logic              req_ok, complete, rd_busy, abort;
    logic              do_issue, do_push, do_pop, last_pop, drain_play, do_load;
    logic [ADDR_W-1:0] req_start, req_len, load_start, load_len;
    logic              unused_frdata_lo;

    assign unused_frdata_lo = ^fm_frdata[7:0];

    assign req_start  = tab_start_q[play_sel];
    assign req_len    = tab_len_q[play_sel];
    assign req_ok     = play_req && (req_len != '0);
    // Read completion is the busy falling edge while a read is in flight.
    assign complete   = rd_out_q && busy_q && !fm_busy;
    // A read that will still be in flight after this cycle.
    assign rd_busy    = rd_out_q && !complete;
    assign abort      = (state_q == StPlay) && (stop || req_ok);
    assign do_issue   = (state_q == StPlay) && !abort && (fetch_cnt_q != '0) && !rd_out_q &&
                        !fm_busy && (count_q != FullC);
    assign do_push    = (state_q == StPlay) && !abort && complete;
    assign do_pop     = (state_q == StPlay) && !abort && ready && (count_q != '0);
    assign last_pop   = do_pop && (play_cnt_q == ADDR_W'(1));
    // What DRAIN does once the stale word lands: stop cancels, a fresh request replaces.
    assign drain_play = stop ? 1'b0 : (req_ok ? 1'b1 : pend_play_q);

    // Decide when a clip is (re)started and which table values it uses.
    always_comb begin
        do_load    = 1'b0;
        load_start = req_start;
        load_len   = req_len;
        case (state_q)
            StIdle:  do_load = !(record_en && !fm_busy) && req_ok;
            StPlay:  do_load = !stop && req_ok && !rd_busy;
            StDrain: begin
                do_load = complete && drain_play;
                if (stop || !req_ok) begin
                    load_start = pend_start_q;
                    load_len   = pend_len_q;
                end
            end
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (record_en && !fm_busy) begin
                    state_d = StRecEnter;
                end else if (req_ok) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                if (stop) begin
                    state_d = rd_busy ? StDrain : StIdle;
                end else if (req_ok) begin
                    state_d = rd_busy ? StDrain : StPlay;
                end else if (last_pop) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (complete) begin
                    state_d = drain_play ? StPlay : StIdle;
                end
            end
            StRecEnter: state_d = StRec;
            StRec: begin
                if (!record_en) begin
                    state_d = StRecExit;
                end
            end
            StRecExit: begin
                if (!fm_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; strobes are combinational so they can never coincide with busy.
    always_comb begin
        fm_writemode = (state_q == StRecEnter) || (state_q == StRec) || (state_q == StRecExit);
        fm_doread    = do_issue;
        fm_raddr     = do_issue ? fetch_addr_q : raddr_q;
        fm_dowrite   = (state_q == StRec) && wr_valid && !fm_busy;
        fm_wdata     = fm_dowrite ? {wr_byte, 8'h00} : wdata_q;
        playing      = (state_q == StPlay);
        to_ac97_data = ac97_q;
        underrun     = underrun_q;
        wr_overflow  = overflow_q;
    end

    // Prefetch FIFO storage.
    always_ff @(posedge clock) begin
        if (do_push) begin
            fifo_mem_q[wptr_q] <= fm_frdata[15:8];
        end
    end

    // Clip table, fetch/play counters, FIFO pointers, sample output and record status.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NCLIPS; i++) begin
                tab_start_q[i] <= '0;
                tab_len_q[i]   <= '0;
            end
            fetch_addr_q <= '0;
            fetch_cnt_q  <= '0;
            play_cnt_q   <= '0;
            raddr_q      <= '0;
            pend_start_q <= '0;
            pend_len_q   <= '0;
            pend_play_q  <= 1'b0;
            rd_out_q     <= 1'b0;
            busy_q       <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            ac97_q       <= 8'h00;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
            wdata_q      <= 16'h0000;
        end else begin
            if (cfg_we) begin
                tab_start_q[cfg_sel] <= cfg_start;
                tab_len_q[cfg_sel]   <= cfg_len;
            end
            busy_q <= fm_busy;

            if (do_issue) begin
                rd_out_q     <= 1'b1;
                raddr_q      <= fetch_addr_q;
                fetch_addr_q <= fetch_addr_q + ADDR_W'(1);
                fetch_cnt_q  <= fetch_cnt_q - ADDR_W'(1);
            end else if (complete) begin
                rd_out_q <= 1'b0;
            end

            if (do_push) begin
                wptr_q <= wptr_q + PtrW'(1);
            end

            underrun_q <= 1'b0;
            if (do_pop) begin
                ac97_q     <= fifo_mem_q[rptr_q];
                rptr_q     <= rptr_q + PtrW'(1);
                play_cnt_q <= play_cnt_q - ADDR_W'(1);
            end else if (ready && !abort) begin
                // Empty FIFO while playing is an underrun; outside playback the output rests.
                ac97_q     <= 8'h00;
                underrun_q <= (state_q == StPlay);
            end

            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: ;
            endcase

            // Remember what to do after the in-flight word has been discarded.
            if (abort && rd_busy) begin
                pend_play_q  <= !stop;
                pend_start_q <= req_start;
                pend_len_q   <= req_len;
            end else if (state_q == StDrain) begin
                if (stop) begin
                    pend_play_q <= 1'b0;
                end else if (req_ok) begin
                    pend_play_q  <= 1'b1;
                    pend_start_q <= req_start;
                    pend_len_q   <= req_len;
                end
            end

            if (do_load) begin
                fetch_addr_q <= load_start;
                fetch_cnt_q  <= load_len;
                play_cnt_q   <= load_len;
                wptr_q       <= '0;
                rptr_q       <= '0;
                count_q      <= '0;
            end

            if (fm_dowrite) begin
                wdata_q <= {wr_byte, 8'h00};
            end
            if ((state_q == StRec) && wr_valid && fm_busy) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clip_sequencer.sv
// Scoreboard bench for clip_sequencer with a behavioural flash model.
module tb_clip_sequencer;

    localparam int AW = 23;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ready = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_sel = 2'd0;
    logic [AW-1:0] cfg_start = '0;
    logic [AW-1:0] cfg_len = '0;
    logic          play_req = 1'b0;
    logic [1:0]    play_sel = 2'd0;
    logic          stop = 1'b0;
    logic          record_en = 1'b0;
    logic [7:0]    wr_byte = 8'h00;
    logic          wr_valid = 1'b0;
    logic [7:0]    to_ac97_data;
    logic          playing, underrun, wr_overflow, fm_writemode, fm_dowrite, fm_doread;
    logic [15:0]   fm_wdata;
    logic [AW-1:0] fm_raddr;
    logic          fm_busy;
    logic [15:0]   fm_frdata;
    logic          busy_m;
    logic          hold_busy = 1'b0;

    assign fm_busy = busy_m | hold_busy;

    clip_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .ready        (ready),
        .cfg_we       (cfg_we),
        .cfg_sel      (cfg_sel),
        .cfg_start    (cfg_start),
        .cfg_len      (cfg_len),
        .play_req     (play_req),
        .play_sel     (play_sel),
        .stop         (stop),
        .record_en    (record_en),
        .wr_byte      (wr_byte),
        .wr_valid     (wr_valid),
        .to_ac97_data (to_ac97_data),
        .playing      (playing),
        .underrun     (underrun),
        .wr_overflow  (wr_overflow),
        .fm_writemode (fm_writemode),
        .fm_wdata     (fm_wdata),
        .fm_dowrite   (fm_dowrite),
        .fm_raddr     (fm_raddr),
        .fm_doread    (fm_doread),
        .fm_busy      (fm_busy),
        .fm_frdata    (fm_frdata)
    );

    always #5 clock = ~clock;

    // Flash model: busy for lat cycles after a strobe, read data {addr[7:0], 55}.
    int            lat = 3;
    int            lat_cnt;
    logic [AW-1:0] pend_a;
    always @(posedge clock) begin
        if (reset) begin
            busy_m    <= 1'b0;
            lat_cnt   <= 0;
            fm_frdata <= 16'h0000;
            pend_a    <= '0;
        end else if (fm_doread || fm_dowrite) begin
            busy_m  <= 1'b1;
            lat_cnt <= lat;
            pend_a  <= fm_raddr;
        end else if (busy_m) begin
            if (lat_cnt <= 1) begin
                busy_m    <= 1'b0;
                fm_frdata <= {pend_a[7:0], 8'h55};
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    // AC97 ready strobe generator.
    int rdy_period = 20;
    bit ready_en = 1'b0;
    initial begin
        int c;
        c = 0;
        forever begin
            @(posedge clock);
            #1;
            c++;
            if (c >= rdy_period) c = 0;
            ready = ready_en && (c == 0);
        end
    end

    logic [7:0]    exp_smp[$];
    logic [AW-1:0] exp_addr[$];
    logic [15:0]   exp_wr[$];
    logic [AW-1:0] m_start[4];
    logic [AW-1:0] m_len[4];
    int n_chk = 0;
    int n_fail = 0;
    int n_under = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented sample, read and write against the queues.
    bit rdy_pend = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            rdy_pend = 1'b0;
        end else begin
            if (rdy_pend) begin
                if (underrun) begin
                    n_under++;
                    chk("underrun_data", 32'(to_ac97_data), 32'h0);
                    chk("underrun_playing", 32'(playing), 32'd1);
                end else if (exp_smp.size() > 0) begin
                    chk("sample", 32'(to_ac97_data), 32'(exp_smp.pop_front()));
                    chk("playing_after_pop", 32'(playing), 32'(exp_smp.size() != 0));
                end else begin
                    chk("idle_sample", 32'(to_ac97_data), 32'h0);
                    chk("idle_playing", 32'(playing), 32'h0);
                end
            end
            rdy_pend = ready;
            if (fm_doread) begin
                chk("rd_exclusive", 32'({fm_dowrite, fm_busy}), 32'h0);
                if (exp_addr.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_read: got addr %h, expected no read", fm_raddr);
                end else begin
                    chk("rd_addr", 32'(fm_raddr), 32'(exp_addr.pop_front()));
                end
            end
            if (fm_dowrite) begin
                chk("wr_exclusive", 32'({fm_doread, fm_busy}), 32'h0);
                if (exp_wr.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got wdata %h, expected no write", fm_wdata);
                end else begin
                    chk("wr_data", 32'(fm_wdata), 32'(exp_wr.pop_front()));
                end
            end
            if (playing && record_en) chk("writemode_in_play", 32'(fm_writemode), 32'h0);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic flush();
        exp_smp.delete();
        exp_addr.delete();
    endtask

    task automatic cfg(input int sel, input logic [AW-1:0] st, input logic [AW-1:0] ln);
        cfg_we    = 1'b1;
        cfg_sel   = sel[1:0];
        cfg_start = st;
        cfg_len   = ln;
        tick();
        cfg_we       = 1'b0;
        m_start[sel] = st;
        m_len[sel]   = ln;
    endtask

    // accept: whether the block is in a mode that honours play requests.
    task automatic play(input int sel, input bit accept);
        bit            en;
        logic [AW-1:0] a;
        en       = ready_en;
        ready_en = 1'b0;
        tick(2);
        play_req = 1'b1;
        play_sel = sel[1:0];
        tick();
        play_req = 1'b0;
        if (accept && (m_len[sel] != 0)) begin
            flush();
            for (int i = 0; i < int'(m_len[sel]); i++) begin
                a = m_start[sel] + AW'(i);
                exp_addr.push_back(a);
                exp_smp.push_back(a[7:0]);
            end
        end
        ready_en = en;
    endtask

    task automatic do_stop(input bit with_req, input int sel);
        stop     = 1'b1;
        play_req = with_req;
        play_sel = sel[1:0];
        tick();
        stop     = 1'b0;
        play_req = 1'b0;
        flush();
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while ((exp_smp.size() != 0 || playing) && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
        if (n >= budget) flush();
    endtask

    task automatic wait_addr_left(input int left, input int budget, input string name);
        int n;
        n = 0;
        while (exp_addr.size() > left && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_playing(input int budget, input string name);
        int n;
        n = 0;
        while (!playing && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(playing), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (fm_busy && n < 100) begin
            tick();
            n++;
        end
        chk("wr_busy_wait", 32'(fm_busy), 32'h0);
        wr_byte  = b;
        wr_valid = 1'b1;
        exp_wr.push_back({b, 8'h00});
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ac97"}, 32'(to_ac97_data), 32'h0);
        chk({tag, "_playing"}, 32'(playing), 32'h0);
        chk({tag, "_underrun"}, 32'(underrun), 32'h0);
        chk({tag, "_overflow"}, 32'(wr_overflow), 32'h0);
        chk({tag, "_writemode"}, 32'(fm_writemode), 32'h0);
        chk({tag, "_wdata"}, 32'(fm_wdata), 32'h0);
        chk({tag, "_dowrite"}, 32'(fm_dowrite), 32'h0);
        chk({tag, "_raddr"}, 32'(fm_raddr), 32'h0);
        chk({tag, "_doread"}, 32'(fm_doread), 32'h0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got time limit, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            sel, n, u0;
        logic [AW-1:0] st, ln;
        for (int i = 0; i < 4; i++) begin
            m_start[i] = '0;
            m_len[i]   = '0;
        end

        tick(3);
        @(negedge clock);
        chk_outputs_zero("reset");
        tick();
        reset = 1'b0;
        tick(2);

        // Normal playback.
        lat = 3; rdy_period = 20; ready_en = 1'b1;
        cfg(1, 23'h100, 23'd5);
        play(1, 1'b1);
        wait_done(2000, "normal_done");
        tick(45);

        // Underrun: slow flash, ready faster than reads.
        lat = 2000; rdy_period = 562;
        u0 = n_under;
        play(1, 1'b1);
        wait_done(20000, "underrun_done");
        chk("underrun_seen", 32'(n_under > u0), 32'd1);
        tick(600);

        // Preempt while a clip 1 read is outstanding.
        lat = 50; rdy_period = 20; ready_en = 1'b0;
        tick(2);
        cfg(2, 23'h2040, 23'd3);
        play(1, 1'b1);
        wait_addr_left(4, 50, "preempt_first_read");
        tick(10);
        chk("preempt_outstanding", 32'(fm_busy), 32'd1);
        play(2, 1'b1);
        wait_playing(200, "preempt_restart");
        ready_en = 1'b1;
        wait_done(3000, "preempt_done");
        ready_en = 1'b0;
        tick(2);

        // Stop with a read outstanding.
        play(1, 1'b1);
        wait_addr_left(4, 50, "stop_first_read");
        tick(5);
        do_stop(1'b0, 0);
        tick(100);
        chk("stop_idle", 32'(playing), 32'h0);

        // Stop and play_req together: stop wins.
        lat = 3;
        play(1, 1'b1);
        tick(2);
        do_stop(1'b1, 2);
        tick(20);
        chk("stop_wins", 32'(playing), 32'h0);

        // Zero-length clip is ignored.
        cfg(0, 23'h500, 23'd0);
        play(0, 1'b1);
        tick(10);
        chk("len0_ignored", 32'(playing), 32'h0);

        // Mode guard, then recording.
        rdy_period = 20; ready_en = 1'b1;
        play(1, 1'b1);
        tick(5);
        record_en = 1'b1;
        wait_done(2000, "guard_done");
        n = 0;
        while (!fm_writemode && n < 50) begin
            tick();
            n++;
        end
        chk("rec_writemode", 32'(fm_writemode), 32'd1);
        tick(2);
        play(1, 1'b0);
        tick(10);
        chk("rec_play_ignored", 32'(playing), 32'h0);
        lat = 2;
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_byte(8'h7E);
        tick(10);
        hold_busy = 1'b1;
        tick();
        wr_byte  = 8'h99;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
        chk("overflow_set", 32'(wr_overflow), 32'd1);
        hold_busy = 1'b0;
        tick(3);
        chk("overflow_sticky", 32'(wr_overflow), 32'd1);
        chk("writes_all_seen", 32'(exp_wr.size()), 32'h0);
        record_en = 1'b0;
        tick(10);
        chk("writemode_exit", 32'(fm_writemode), 32'h0);

        // Randomized clips.
        for (int k = 0; k < 8; k++) begin
            sel = int'($urandom_range(0, 3));
            st  = AW'($urandom);
            ln  = AW'($urandom_range(1, 6));
            lat = int'($urandom_range(1, 8));
            rdy_period = int'($urandom_range(12, 40));
            cfg(sel, st, ln);
            play(sel, 1'b1);
            wait_done(4000, "random_done");
        end

        // Reset in the middle of playback.
        lat = 4; rdy_period = 15;
        cfg(3, 23'h3A1, 23'd6);
        play(3, 1'b1);
        n = 0;
        while (exp_smp.size() > 4 && n < 1000) begin
            tick();
            n++;
        end
        chk("reset_pre_samples", 32'(n < 1000), 32'd1);
        ready_en = 1'b0;
        tick(2);
        flush();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk_outputs_zero("midreset");
        tick();
        reset = 1'b0;
        tick(5);

        chk("smp_queue_empty", 32'(exp_smp.size()), 32'h0);
        chk("addr_queue_empty", 32'(exp_addr.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
